hazard_stall_controller: RTL

Pipeline sequencing controller for the 5-stage MIPS core. It sits between the IF/ID register, the ID/EX pipeline register and the PC. It decides each cycle whether the front end advances, stalls or is squashed. It resolves three events:
- load-use hazards, with a one-bubble stall;
- taken branches resolved in EX, which flush IF/ID and ID/EX;
- multi-cycle mult/div issue, which holds the front end for a fixed number of cycles.

It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_stall_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use, branch-flush and mult/div stall sequencing for the 5-stage core
// Advance/stall/flush decisions are combinational; state, wait count and stall counter are registered.
module hazard_stall_controller #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_RT,
  input  logic [4:0]       IFID_RS,
  input  logic [4:0]       IFID_RT,
  input  logic             IFID_UsesRT,
  input  logic             IFID_MulDiv,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCycles
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MD_WAIT} state_t;

  localparam logic [7:0] MD_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             luse;

  assign luse = IDEX_MemRead && (IDEX_RT != 5'd0) &&
                ((IDEX_RT == IFID_RS) || (IFID_UsesRT && (IDEX_RT == IFID_RT)));

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (!Rst_n || BranchTaken) begin
      // squash both front-end registers; any pending stall dies with the ID instruction
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      state_d   = RUN;
      cnt_d     = 8'd0;
    end else begin
      unique case (state_q)
        RUN, LOAD_STALL: begin
          if (state_q == RUN && luse) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            state_d   = LOAD_STALL;
          end else if (IFID_MulDiv) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            cnt_d     = MD_LOAD;
            state_d   = MD_WAIT;
          end else begin
            state_d   = RUN;
          end
        end
        MD_WAIT: begin
          if (cnt_q != 8'd0) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            cnt_d     = cnt_q - 8'd1;
          end else begin
            state_d   = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!PCWrite && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign Busy        = Rst_n && (state_q != RUN);
  assign StallCycles = stall_q;

endmodule
